apb_slave_regfile: RTL and testbench
====================================

Name: apb_slave_regfile

Overview:
- APB3 completer (slave) holding a word-addressed register file.
- Sits behind an APB requester (master) driver on a single pclk domain.
- Accepts single write and read transfers; read data reflects the last completed write to the same word.
- Used as the loop-back target for requester write/read-compare tests.

Parameters:
- ADDR_W, 32, paddr width.
- DATA_W, 32, pwdata/prdata width.
- MEM_DEPTH, 256, number of DATA_W words; power of two, min 4.
- FULL_DECODE, 0
  - 0: paddr bits above the word index are ignored (aliasing).
  - 1: any such bit set is an error.

Ports:
- pclk  in  1  clock; all logic on the rising edge.
- preset  in  1  synchronous, active-high reset.
- psel  in  1  completer select.
- penable  in  1  access-phase strobe.
- pwrite  in  1  1 = write, 0 = read.
- paddr  in  ADDR_W  byte address.
- pwdata  in  DATA_W  write data.
- prdata  out  DATA_W  read data, valid while pready=1 in a read access.
- pready  out  1  transfer completion.
- pslverr  out  1  error response, valid while pready=1.

Behaviour:
- Interface: one clock (pclk); reset is synchronous and active-high (preset). No asynchronous logic.
- Word index:
  - IDX = paddr[log2(MEM_DEPTH)+1 : 2].
  - paddr[1:0] ignored; no byte strobes.
- Reset (preset=1 at a pclk edge):
  - state=IDLE; prdata=0, pready=0, pslverr=0.
  - All MEM_DEPTH words cleared to 0.
  - Reset overrides any transfer in flight. An aborted write does not modify memory.
- State machine: IDLE, SETUP, ACCESS.
  - IDLE: psel=1 and penable=0 -> SETUP. psel=0 -> stay in IDLE.
  - SETUP: latch pwrite, IDX and error flag. For a read, register mem[IDX] into prdata. Always -> ACCESS next cycle.
  - ACCESS: completes when psel=1, penable=1 and pready=1.
    - On completion: a write without error stores pwdata into mem[IDX].
    - Next state: psel=1 and penable=0 -> SETUP (back-to-back transfer); otherwise -> IDLE.
  - Protocol violation: psel dropping, or penable=0 while in ACCESS, forces IDLE with no memory update.
  - penable=1 while in IDLE is ignored.
- pready:
  - Base build: 1 in every ACCESS cycle (zero wait states); 0 otherwise.
- prdata:
  - Holds the value registered in SETUP through ACCESS.
  - Returns to 0 on the cycle after the transfer completes.
  - Writes leave prdata unchanged.
- Read-after-write: a read of a word in the transfer immediately after a write to it returns the new data. The write commits at the edge ending ACCESS, before the read's SETUP sample.
- pslverr:
  - Asserted with pready only when FULL_DECODE=1 and any paddr bit above IDX is set; 0 otherwise.
  - An erroring write leaves memory unchanged.
  - An erroring read returns prdata=0.
- Outputs are registered or decoded from state only; no combinational path from pwdata to prdata.

Optional Feature:
- Macro: APB_SL_WAIT_STATE_EN.
- Defined: adds parameter WAIT_CYCLES (default 2).
  - On entering ACCESS, a down-counter loads WAIT_CYCLES.
  - pready stays 0 while the counter is non-zero; the counter decrements each ACCESS cycle.
  - pready=1 when the counter reaches 0.
  - Memory write, prdata validity and pslverr follow the pready=1 cycle.
  - WAIT_CYCLES=0 behaves as the base build.
- Undefined: zero wait states; no counter logic present.

Test Plan:
- Reset for 10 cycles, then read paddr=0x0000_0010 -> prdata=0x0000_0000, pready=1 in ACCESS, pslverr=0.
- Write paddr=0x1234_5678 data 0xDEAD_BEEF, then read paddr=0x1234_5678 -> prdata=0xDEAD_BEEF. With FULL_DECODE=0, reading 0x0000_0278 (same IDX) also returns 0xDEAD_BEEF.
- Back-to-back transfers (SETUP directly after ACCESS):
  - write 0x04=0xA5A5_0001, write 0x08=0x5A5A_0002, read 0x04 -> 0xA5A5_0001, read 0x08 -> 0x5A5A_0002.
  - Each transfer takes 2 cycles.
- FULL_DECODE=1: write 0x0001_0000 with 0xFFFF_FFFF -> pslverr=1. Then read 0x0000_0000 -> 0, memory unchanged.
- Assert preset during ACCESS of a write to 0x0C -> state IDLE, outputs 0. Subsequent read of 0x0C -> 0.
- APB_SL_WAIT_STATE_EN with WAIT_CYCLES=2: a write takes 4 cycles (SETUP + 3 ACCESS), with pready=0,0,1. The following read returns the written data.

Source files
------------

// File: rtl/apb_slave_regfile.sv
// apb_slave_regfile: APB3 completer over a word-addressed register file.
// Optional wait states via `APB_SL_WAIT_STATE_EN (adds parameter WAIT_CYCLES).
module apb_slave_regfile #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_DEPTH   = 256,
    parameter bit FULL_DECODE = 1'b0
`ifdef APB_SL_WAIT_STATE_EN
    ,
    parameter int WAIT_CYCLES = 2
`endif
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [DATA_W-1:0] pwdata,
    output logic [DATA_W-1:0] prdata,
    output logic              pready,
    output logic              pslverr
);
    localparam int AW = $clog2(MEM_DEPTH);
    localparam logic [ADDR_W-1:0] HI_MASK = {ADDR_W{1'b1}} << (AW + 2);

    // The setup phase is acted on at the edge that samples it, so ACCESS follows directly
    typedef enum logic {IDLE, ACCESS} state_e;

    state_e            state_q;
    logic              write_q;
    logic              err_q;
    logic [AW-1:0]     idx_q;
    logic [DATA_W-1:0] prdata_q;
    logic [DATA_W-1:0] mem_q [MEM_DEPTH];

    logic          setup;
    logic          err_d;
    logic [AW-1:0] idx_d;

    assign setup   = state_q == IDLE && psel && !penable;
    assign err_d   = FULL_DECODE && |(paddr & HI_MASK);
    assign idx_d   = paddr[AW+1:2];
    assign prdata  = prdata_q;
    assign pslverr = pready && err_q;

`ifdef APB_SL_WAIT_STATE_EN
    localparam int CW = $clog2(WAIT_CYCLES + 2);
    logic [CW-1:0] cnt_q;
    assign pready = state_q == ACCESS && cnt_q == '0;
    always_ff @(posedge pclk) begin
        if (preset)
            cnt_q <= '0;
        else if (setup)
            cnt_q <= CW'(WAIT_CYCLES);
        else if (state_q == ACCESS && psel && penable && cnt_q != '0)
            cnt_q <= cnt_q - 1'b1;
    end
`else
    assign pready = state_q == ACCESS;
`endif

    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q  <= IDLE;
            write_q  <= 1'b0;
            err_q    <= 1'b0;
            idx_q    <= '0;
            prdata_q <= '0;
            for (int i = 0; i < MEM_DEPTH; i++)
                mem_q[i] <= '0;
        end else if (state_q == IDLE) begin
            if (setup) begin
                state_q <= ACCESS;
                write_q <= pwrite;
                err_q   <= err_d;
                idx_q   <= idx_d;
                if (!pwrite)
                    prdata_q <= err_d ? '0 : mem_q[idx_d];
            end
        end else if (!(psel && penable)) begin
            state_q  <= IDLE;
            prdata_q <= '0;
        end else if (pready) begin
            state_q  <= IDLE;
            prdata_q <= '0;
            if (write_q && !err_q)
                mem_q[idx_q] <= pwdata;
        end
    end
endmodule

// File: tb/tb_apb_slave_regfile.sv
// tb_apb_slave_regfile: directed table-driven bench for apb_slave_regfile.
// Runs an aliasing instance and a FULL_DECODE instance side by side on one bus.
module tb_apb_slave_regfile;
`ifdef APB_SL_WAIT_STATE_EN
    localparam int WAITS = 2;
`else
    localparam int WAITS = 0;
`endif

    logic        pclk = 1'b0;
    logic        preset = 1'b1;
    logic        psel = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [31:0] paddr = '0;
    logic [31:0] pwdata = '0;
    logic [31:0] prdata, prdata_fd;
    logic        pready, pready_fd, pslverr, pslverr_fd;

    int checks = 0;
    int errors = 0;

    always #5 pclk = ~pclk;

    apb_slave_regfile #(
        .FULL_DECODE(1'b0)
`ifdef APB_SL_WAIT_STATE_EN
        ,
        .WAIT_CYCLES(WAITS)
`endif
    ) u_dut (
        .pclk(pclk), .preset(preset), .psel(psel), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    apb_slave_regfile #(
        .FULL_DECODE(1'b1)
`ifdef APB_SL_WAIT_STATE_EN
        ,
        .WAIT_CYCLES(WAITS)
`endif
    ) u_dut_fd (
        .pclk(pclk), .preset(preset), .psel(psel), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata_fd), .pready(pready_fd), .pslverr(pslverr_fd)
    );

    typedef struct {
        logic        w;
        logic        b2b;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] erd;
        logic [31:0] erdf;
        logic        eer;
        logic        eerf;
    } vec_t;

    vec_t v[14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle();
        psel = 1'b0;
        penable = 1'b0;
        @(posedge pclk);
        #1;
    endtask

    // Setup phase starts now; returns #1 after the completion edge with psel still high
    task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic [31:0] rdf,
                        output logic er, output logic erf, output int cyc);
        psel = 1'b1;
        penable = 1'b0;
        pwrite = w;
        paddr = a;
        pwdata = d;
        @(posedge pclk);
        #1 penable = 1'b1;
        @(negedge pclk);
        cyc = 2;
        while (!pready && cyc < 20) begin
            @(negedge pclk);
            cyc++;
        end
        if (!pready) begin
            checks++;
            errors++;
            $display("FAIL xfer_timeout addr=%h: pready still 0 after %0d cycles, required 1", a, cyc);
        end
        rd = prdata;
        rdf = prdata_fd;
        er = pslverr;
        erf = pslverr_fd;
        @(posedge pclk);
        #1;
    endtask

    initial begin
        logic [31:0] rd, rdf;
        logic        er, erf;
        int          cyc;

        v[0]  = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,          32'h0,          32'h0,          1'b0, 1'b0};
        v[1]  = '{1'b1, 1'b0, 32'h1234_5678, 32'hDEAD_BEEF,  32'h0,          32'h0,          1'b0, 1'b1};
        v[2]  = '{1'b0, 1'b0, 32'h1234_5678, 32'h0,          32'hDEAD_BEEF,  32'h0,          1'b0, 1'b1};
        v[3]  = '{1'b0, 1'b0, 32'h0000_0278, 32'h0,          32'hDEAD_BEEF,  32'h0,          1'b0, 1'b0};
        v[4]  = '{1'b1, 1'b0, 32'h0000_0004, 32'hA5A5_0001,  32'h0,          32'h0,          1'b0, 1'b0};
        v[5]  = '{1'b1, 1'b1, 32'h0000_0008, 32'h5A5A_0002,  32'h0,          32'h0,          1'b0, 1'b0};
        v[6]  = '{1'b0, 1'b1, 32'h0000_0004, 32'h0,          32'hA5A5_0001,  32'hA5A5_0001,  1'b0, 1'b0};
        v[7]  = '{1'b0, 1'b1, 32'h0000_0008, 32'h0,          32'h5A5A_0002,  32'h5A5A_0002,  1'b0, 1'b0};
        v[8]  = '{1'b1, 1'b0, 32'h0001_0000, 32'hFFFF_FFFF,  32'h0,          32'h0,          1'b0, 1'b1};
        v[9]  = '{1'b0, 1'b0, 32'h0000_0000, 32'h0,          32'hFFFF_FFFF,  32'h0,          1'b0, 1'b0};
        v[10] = '{1'b0, 1'b0, 32'h0000_03FC, 32'h0,          32'h0,          32'h0,          1'b0, 1'b0};
        v[11] = '{1'b1, 1'b0, 32'h0000_03FC, 32'h1357_9BDF,  32'h0,          32'h0,          1'b0, 1'b0};
        v[12] = '{1'b0, 1'b1, 32'h0000_03FC, 32'h0,          32'h1357_9BDF,  32'h1357_9BDF,  1'b0, 1'b0};
        v[13] = '{1'b0, 1'b1, 32'h0000_03FE, 32'h0,          32'h1357_9BDF,  32'h1357_9BDF,  1'b0, 1'b0};

        repeat (10) @(posedge pclk);
        @(negedge pclk);
        chk("reset_prdata", prdata, 32'h0);
        chk("reset_pready", 32'(pready), 32'h0);
        chk("reset_pslverr", 32'(pslverr), 32'h0);
        chk("reset_prdata_fd", prdata_fd, 32'h0);
        chk("reset_pready_fd", 32'(pready_fd), 32'h0);
        @(posedge pclk);
        #1 preset = 1'b0;
        idle();

        for (int i = 0; i < 14; i++) begin
            if (!v[i].b2b)
                idle();
            xfer(v[i].w, v[i].a, v[i].d, rd, rdf, er, erf, cyc);
            chk($sformatf("v%0d_prdata", i), rd, v[i].erd);
            chk($sformatf("v%0d_prdata_fd", i), rdf, v[i].erdf);
            chk($sformatf("v%0d_pslverr", i), 32'(er), 32'(v[i].eer));
            chk($sformatf("v%0d_pslverr_fd", i), 32'(erf), 32'(v[i].eerf));
            chk($sformatf("v%0d_cycles", i), 32'(cyc), 32'(2 + WAITS));
        end

        // Bus left at psel=1/penable=1 after completion: an IDLE completer must ignore it
        @(negedge pclk);
        chk("after_done_prdata", prdata, 32'h0);
        chk("idle_penable_pready", 32'(pready), 32'h0);
        @(negedge pclk);
        chk("idle_penable_pready2", 32'(pready), 32'h0);
        @(posedge pclk);
        #1;
        idle();

        // Protocol violation: penable never rises, so the write must be dropped
        psel = 1'b1;
        penable = 1'b0;
        pwrite = 1'b1;
        paddr = 32'h20;
        pwdata = 32'hCAFE_F00D;
        @(posedge pclk);
        #1;
        @(posedge pclk);
        #1;
        idle();
        xfer(1'b0, 32'h20, 32'h0, rd, rdf, er, erf, cyc);
        chk("violation_no_write", rd, 32'h0);
        chk("violation_no_write_fd", rdf, 32'h0);
        idle();

        // Reset during ACCESS of a write to 0x0C
        psel = 1'b1;
        penable = 1'b0;
        pwrite = 1'b1;
        paddr = 32'h0C;
        pwdata = 32'h1111_2222;
        @(posedge pclk);
        #1 penable = 1'b1;
        preset = 1'b1;
        @(posedge pclk);
        #1 preset = 1'b0;
        psel = 1'b0;
        penable = 1'b0;
        @(negedge pclk);
        chk("abort_pready", 32'(pready), 32'h0);
        chk("abort_prdata", prdata, 32'h0);
        chk("abort_pslverr", 32'(pslverr), 32'h0);
        @(posedge pclk);
        #1;
        xfer(1'b0, 32'h0C, 32'h0, rd, rdf, er, erf, cyc);
        chk("abort_read_0c", rd, 32'h0);
        chk("abort_read_0c_cycles", 32'(cyc), 32'(2 + WAITS));
        xfer(1'b0, 32'h04, 32'h0, rd, rdf, er, erf, cyc);
        chk("reset_cleared_04", rd, 32'h0);
        chk("reset_cleared_04_fd", rdf, 32'h0);
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
